serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal 2..32).
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request: begin addition of a, b, cin.
REQ-005 a  input  WIDTH  operand A, sampled only on an accepted start.
REQ-006 b  input  WIDTH  operand B, sampled only on an accepted start.
REQ-007 cin  input  1  carry-in, sampled only on an accepted start.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse when sum/cout become valid.
REQ-010 sum  output  WIDTH  result, held stable until the next accepted start.
REQ-011 cout  output  1  final carry-out, held with sum.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, one bit per clock, using a single one-bit full-adder cell.
REQ-013 The FSM SHALL have states IDLE, RUN and DONE, encoded in 2 bits.
REQ-014 IDLE: start=1 -> latch a, b and cin (carry register = cin), bit counter = 0, go to RUN. start=0 -> stay in IDLE.
REQ-015 RUN: each cycle, process bit[counter]: shift the cell sum into the result register MSB, shift the operand registers right, store the cell carry, and increment the counter.
REQ-016 RUN -> DONE on the cycle that processes bit WIDTH-1. The counter SHALL never exceed WIDTH-1.
REQ-017 DONE: done=1 for exactly this one cycle, then go to IDLE. If start=1 in DONE, it SHALL be accepted as in IDLE (back-to-back) and go to RUN.
REQ-018 Latency: start sampled at edge k -> busy high for cycles k+1..k+WIDTH -> done high in cycle k+WIDTH+1 -> sum/cout valid from that cycle.
REQ-019 start while busy=1 SHALL be ignored, with no effect on the operands or the result.
REQ-020 sum and cout SHALL update only when entering DONE; intermediate shifts SHALL use an internal register invisible on sum.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH; cout carries bit WIDTH.

Reset
REQ-022 rst_n=0 at a clock edge SHALL force state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0.
REQ-023 Reset during RUN SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-024 Macro SERIAL_ADD_SUB_EN: when defined, an input port op_sub (1 bit) SHALL be added after cin.
- With op_sub=1 on an accepted start: compute a + ~b + 1; cin is ignored; cout=1 means no borrow.
- Without the macro: the port is absent and the block is add-only.

Structure
REQ-025 A shared package serial_add_pkg SHALL hold the state typedef (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-026 The one-bit cell SHALL be the team's existing combinational full_adder, instantiated once. No other sub-modules.

Verification (WIDTH=8)
REQ-027 a=0x00, b=0x00, cin=0, start pulse -> busy for 8 cycles, done in cycle 9 -> sum=0x00, cout=0.
REQ-028 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 issued in the DONE cycle -> accepted back-to-back -> sum=0x00, cout=1.
REQ-029 a=0x12, b=0x34 started; at busy cycle 3 assert start with a=0xFF, b=0xFF -> ignored -> sum=0x46, cout=0.
REQ-030 Start a=0x80, b=0x80; rst_n=0 at busy cycle 4 -> no done, all outputs 0. Then a=0x03, b=0x04 -> sum=0x07.
REQ-031 With SERIAL_ADD_SUB_EN: a=0x05, b=0x07, op_sub=1 -> sum=0xFE, cout=0. Then a=0x07, b=0x05, op_sub=1 -> sum=0x02, cout=1.
REQ-032 A scoreboard SHALL check 1000 random operand/cin sets against a+b+cin, and SHALL check that done is exactly one cycle wide.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder, LSB first, one bit per clock through a single full_adder cell.
// Optional macro SERIAL_ADD_SUB_EN adds an op_sub input for a - b (cout=1 means no borrow).
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             op_sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: start is accepted on any rising edge where the FSM is in IDLE or DONE;
  // it is ignored while busy. done is a one-cycle pulse and sum/cout hold until the
  // next accepted start.
  state_t          state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  full_adder u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_c)
  );

  always_comb begin
    accept = start && (state != RUN);
`ifdef SERIAL_ADD_SUB_EN
    b_eff  = op_sub ? ~b : b;
    c_eff  = op_sub ? 1'b1 : cin;
`else
    b_eff  = b;
    c_eff  = cin;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_a  <= a;
        op_b  <= b_eff;
        carry <= c_eff;
        acc   <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
        state <= RUN;
      end else begin
        case (state)
          RUN: begin
            // acc fills from the MSB so the LSB-first bits land in place after WIDTH shifts
            acc   <= {fa_s, acc[WIDTH-1:1]};
            op_a  <= op_a >> 1;
            op_b  <= op_b >> 1;
            carry <= fa_c;
            if (cnt == CW'(WIDTH - 1)) begin
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              sum   <= {fa_s, acc[WIDTH-1:1]};
              cout  <= fa_c;
              state <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
